rptr_empty_ctrl: RTL and testbench
==================================

Name: rptr_empty_ctrl

Overview:
Read-side pointer and status controller for the async FIFO, in the rclk domain. It consumes the 2-flop-synchronized Gray write pointer and maintains the binary and Gray read pointers. It drives the memory read address and produces registered empty, almost-empty, fill-level and sticky underflow status. Its Gray read pointer output feeds the read-to-write synchronizer.

Parameters:
ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits (extra wrap bit).
AE_THRESH, 2, ralmost_empty asserts when the fill level is <= AE_THRESH; legal range 0..2**ADDRSIZE.

Ports:
rclk  input  1  read clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
rd_en  input  1  pop request from the read consumer.
clr_underflow  input  1  synchronous clear of the underflow flag.
wptr_sync  input  ADDRSIZE+1  Gray write pointer, already synchronized into rclk.
raddr  output  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0]; the memory read is combinational.
rptr_gray  output  ADDRSIZE+1  registered Gray read pointer, sent to the write domain.
rempty  output  1  registered empty flag.
ralmost_empty  output  1  registered; asserted when level <= AE_THRESH.
rlevel  output  ADDRSIZE+1  registered fill-level estimate, 0..2**ADDRSIZE.
underflow  output  1  sticky; set by a pop attempted while empty.

Behaviour:
- Reset (async, rst=1) forces: rbin=0, rptr_gray=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0, underflow=0. State is held while rst is high. A reset mid-operation discards all pointer state immediately; the write side must be reset together with this block.
- pop = rd_en & ~rempty. A pop request while empty is ignored: pointers are unchanged.
- rbin_next = rbin + pop, modulo 2**(ADDRSIZE+1).
- rgray_next = rbin_next ^ (rbin_next >> 1).
- Each rclk edge registers rbin <= rbin_next and rptr_gray <= rgray_next.
- rempty <= (rgray_next == wptr_sync).
  - Emptiness is evaluated against the post-pop pointer, so popping the last entry raises rempty on that same edge.
  - There is no combinational path from rd_en to rempty.
- Level:
  - wbin_sync = Gray-to-binary of wptr_sync: bit i = XOR of wptr_sync[ADDRSIZE:i].
  - level_next = (wbin_sync - rbin_next) modulo 2**(ADDRSIZE+1).
  - rlevel <= level_next.
  - ralmost_empty <= (level_next <= AE_THRESH).
- Latency:
  - A pop updates raddr, rptr_gray, rempty and rlevel at the same edge it is accepted.
  - A change on wptr_sync is reflected in rempty, rlevel and ralmost_empty one rclk edge later.
- Pessimism is required behaviour: wptr_sync lags the true write pointer, so rlevel may under-report and rempty may assert early. rempty must never deassert while the FIFO is truly empty.
- Simultaneous wptr_sync change and pop: both are used in the same next-state computation.
- Wrap-around: the pointer MSB toggles every 2**ADDRSIZE pops, and raddr wraps from 2**ADDRSIZE-1 to 0. Full = 2**ADDRSIZE entries: rlevel = 2**ADDRSIZE with the MSBs differing.
- underflow:
  - Set on any edge with rd_en & rempty.
  - Cleared by clr_underflow otherwise.
  - If both occur in the same cycle, set wins.
- wptr_sync is assumed Gray-coded, changing by at most one bit per rclk; no checking is done on it.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> immediately rempty=1, ralmost_empty=1, rlevel=0, rptr_gray=0, raddr=0, underflow=0.
2. Single entry: wptr_sync 0->5'b00001 -> next edge rempty=0, rlevel=1. Then rd_en for 1 cycle -> same edge raddr=1, rptr_gray=5'b00001, rempty=1, rlevel=0.
3. Underflow: with rempty=1, rd_en=1 for 2 cycles -> rbin unchanged, underflow=1 after the first edge. clr_underflow with rd_en=0 -> underflow=0. clr_underflow with rd_en=1 in the same cycle -> underflow stays 1.
4. Full and wrap (ADDRSIZE=4): wptr_sync = Gray(16) = 5'b11000 -> rlevel=16. Pop 16 times -> raddr=0, rptr_gray=5'b11000, rempty=1. Repeat through Gray(32 mod 32)=0 -> pointers wrap to 0 with no glitch on rempty.
5. Almost-empty (AE_THRESH=2): level 3 -> ralmost_empty=0. Pop one -> rlevel=2, ralmost_empty=1. wptr_sync advances by one in the same cycle as a pop -> rlevel stays 3.
6. Reset mid-stream: at rlevel=5, rbin=7, pulse rst -> all outputs return to their reset values. After release with wptr_sync=0 -> rempty stays 1.

Source files
------------

// File: rtl/rptr_empty_ctrl.sv
// ---------------------------------------------------------------------------
// rptr_empty_ctrl
//   Read-side pointer and status controller of an asynchronous FIFO, running
//   in the rclk domain. It keeps the binary and Gray read pointers, drives the
//   memory read address, and produces registered empty, almost-empty,
//   fill-level and sticky underflow status. The status is derived from the
//   write pointer after it has been synchronized into rclk.
//
// Parameters
//   ADDRSIZE  : FIFO address width; depth = 2**ADDRSIZE. Pointers carry one
//               extra wrap bit (ADDRSIZE+1 bits).
//   AE_THRESH : ralmost_empty is asserted while the fill level <= AE_THRESH.
//
// Ports
//   rclk          in   read clock, rising edge
//   rst           in   asynchronous, active-high reset
//   rd_en         in   pop request from the consumer
//   clr_underflow in   synchronous clear of the underflow flag
//   wptr_sync     in   Gray write pointer, already synchronized into rclk
//   raddr         out  memory read address (low bits of binary read pointer)
//   rptr_gray     out  registered Gray read pointer, for the write domain
//   rempty        out  registered empty flag
//   ralmost_empty out  registered, level <= AE_THRESH
//   rlevel        out  registered fill-level estimate, 0..2**ADDRSIZE
//   underflow     out  sticky, set by a pop attempted while empty
// ---------------------------------------------------------------------------
module rptr_empty_ctrl #(
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                clr_underflow,
    input  logic [ADDRSIZE:0]   wptr_sync,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr_gray,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                underflow
);

    localparam logic [ADDRSIZE:0] AE_LIMIT = (ADDRSIZE+1)'(AE_THRESH);

    function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bit i of the binary value is the XOR of all Gray bits from i upwards.
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] rbin;
    logic              pop;
    logic [ADDRSIZE:0] rbin_next;
    logic [ADDRSIZE:0] rgray_next;
    logic [ADDRSIZE:0] wbin_sync;
    logic [ADDRSIZE:0] level_next;

    // ---- next-state computation (combinational) ----
    // Empty and level are judged against the post-pop pointer so the last pop
    // raises rempty on the same edge. The synchronized write pointer lags the
    // real one, which only makes the status pessimistic, never optimistic.
    always_comb begin
        pop        = rd_en & ~rempty;
        rbin_next  = rbin + {{ADDRSIZE{1'b0}}, pop};
        rgray_next = bin2gray(rbin_next);
        wbin_sync  = gray2bin(wptr_sync);
        level_next = wbin_sync - rbin_next;
    end

    // ---- registered pointers and status ----
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rbin          <= '0;
            rptr_gray     <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
            underflow     <= 1'b0;
        end else begin
            rbin          <= rbin_next;
            rptr_gray     <= rgray_next;
            rempty        <= (rgray_next == wptr_sync);
            ralmost_empty <= (level_next <= AE_LIMIT);
            rlevel        <= level_next;
            // A failed pop outranks a clear issued in the same cycle.
            if (rd_en && rempty)
                underflow <= 1'b1;
            else if (clr_underflow)
                underflow <= 1'b0;
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
module tb_rptr_empty_ctrl;

    logic       rclk = 1'b0;
    logic       rst  = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_underflow = 1'b0;
    logic [4:0] wptr_sync = '0;
    logic [3:0] raddr;
    logic [4:0] rptr_gray;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rlevel;
    logic       underflow;

    int tests = 0;
    int fails = 0;

    // Reference model state: counts of entries read/written, modulo 32.
    int  m_r = 0;
    int  m_w = 0;
    bit  m_empty = 1;
    bit  m_uf = 0;

    rptr_empty_ctrl #(.ADDRSIZE(4), .AE_THRESH(2)) dut (
        .rclk(rclk), .rst(rst), .rd_en(rd_en), .clr_underflow(clr_underflow),
        .wptr_sync(wptr_sync), .raddr(raddr), .rptr_gray(rptr_gray),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel),
        .underflow(underflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray(input int x);
        logic [4:0] v;
        v = 5'(x % 32);
        return v ^ (v >> 1);
    endfunction

    // Packed snapshot: raddr, rptr_gray, rempty, ralmost_empty, rlevel, underflow
    function automatic logic [16:0] pack(input int ra, input int g, input bit e,
                                         input bit ae, input int lv, input bit uf);
        return {4'(ra), 5'(g), e, ae, 5'(lv), uf};
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] act;
        act = {raddr, rptr_gray, rempty, ralmost_empty, rlevel, underflow};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got raddr=%0d gray=%b empty=%b ae=%b lvl=%0d uf=%b (%h), expected %h",
                     name, raddr, rptr_gray, rempty, ralmost_empty, rlevel, underflow, act, exp);
        end
    endtask

    // Asserts reset away from a clock edge and checks that outputs fall to
    // their reset values immediately, before any rclk edge.
    task automatic apply_reset(input string name);
        @(negedge rclk);
        #2;
        rst = 1'b1;
        rd_en = 1'b0;
        clr_underflow = 1'b0;
        wptr_sync = '0;
        #1;
        check(name, pack(0, 0, 1, 1, 0, 0));
        @(posedge rclk);
        #1;
        rst = 1'b0;
        m_r = 0; m_w = 0; m_empty = 1; m_uf = 0;
    endtask

    // One clock with model-predicted results. w is the true write count.
    task automatic mstep(input string name, input bit rd, input bit clr, input int w);
        int lvl;
        bit pop;
        rd_en = rd;
        clr_underflow = clr;
        m_w = w % 32;
        wptr_sync = gray(m_w);
        @(posedge rclk);
        pop = rd && !m_empty;
        if (rd && m_empty) m_uf = 1;
        else if (clr) m_uf = 0;
        m_r = (m_r + (pop ? 1 : 0)) % 32;
        lvl = (m_w - m_r + 32) % 32;
        m_empty = (lvl == 0);
        #1;
        check(name, pack(m_r % 16, gray(m_r), m_empty, lvl <= 2, lvl, m_uf));
    endtask

    typedef struct {
        bit rd;
        bit clr;
        int w;
        int raddr;
        int g;
        bit e;
        bit ae;
        int lvl;
        bit uf;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};  // idle after reset
        vecs[1]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0};  // one entry written
        vecs[2]  = '{1, 0, 1, 1, 1, 1, 1, 0, 0};  // pop last entry
        vecs[3]  = '{1, 0, 1, 1, 1, 1, 1, 0, 1};  // pop while empty
        vecs[4]  = '{1, 0, 1, 1, 1, 1, 1, 0, 1};  // again, pointer held
        vecs[5]  = '{0, 1, 1, 1, 1, 1, 1, 0, 0};  // clear
        vecs[6]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1};  // set beats clear
        vecs[7]  = '{0, 1, 1, 1, 1, 1, 1, 0, 0};  // clear
        vecs[8]  = '{0, 0, 2, 1, 1, 0, 1, 1, 0};
        vecs[9]  = '{0, 0, 3, 1, 1, 0, 1, 2, 0};
        vecs[10] = '{0, 0, 4, 1, 1, 0, 0, 3, 0};  // level 3: not almost empty
        vecs[11] = '{1, 0, 4, 2, 3, 0, 1, 2, 0};  // pop -> level 2
        vecs[12] = '{0, 0, 5, 2, 3, 0, 0, 3, 0};
        vecs[13] = '{1, 0, 6, 3, 2, 0, 0, 3, 0};  // write+pop same cycle
        vecs[14] = '{0, 0, 6, 3, 2, 0, 0, 3, 0};

        // Power-on reset
        #12;
        check("por", pack(0, 0, 1, 1, 0, 0));
        @(posedge rclk);
        #1;
        rst = 1'b0;

        // Table-driven directed vectors
        for (int i = 0; i < 15; i++) begin
            rd_en = vecs[i].rd;
            clr_underflow = vecs[i].clr;
            wptr_sync = gray(vecs[i].w);
            @(posedge rclk);
            #1;
            check($sformatf("vec%0d", i),
                  pack(vecs[i].raddr, vecs[i].g, vecs[i].e, vecs[i].ae, vecs[i].lvl, vecs[i].uf));
        end

        // Asynchronous reset mid-cycle with non-reset state present
        apply_reset("async_rst");

        // Full FIFO and two complete wraps of the read pointer
        mstep("full_lvl", 0, 0, 16);
        check("full_exact", pack(0, 5'b11000 ^ 5'b11000, 0, 0, 16, 0));
        for (int i = 0; i < 16; i++) mstep($sformatf("wrap1_%0d", i), 1, 0, 16);
        check("wrap1_end", pack(0, 5'b11000, 1, 1, 0, 0));
        mstep("refill", 0, 0, 32);
        check("refill_lvl", pack(0, 5'b11000, 0, 0, 16, 0));
        for (int i = 0; i < 16; i++) mstep($sformatf("wrap2_%0d", i), 1, 0, 32);
        check("wrap2_end", pack(0, 0, 1, 1, 0, 0));

        // Reset mid-stream at level 5, read count 7
        apply_reset("pre_stream_rst");
        mstep("ms_fill", 0, 0, 12);
        for (int i = 0; i < 7; i++) mstep($sformatf("ms_pop%0d", i), 1, 0, 12);
        check("ms_state", pack(7, gray(7), 0, 0, 5, 0));
        apply_reset("ms_rst");
        mstep("ms_after0", 0, 0, 0);
        mstep("ms_after1", 0, 0, 0);

        // Randomized traffic against the model
        begin
            int w;
            w = 0;
            for (int n = 0; n < 3000; n++) begin
                bit rd;
                bit clr;
                rd  = ($urandom_range(0, 99) < 45);
                clr = ($urandom_range(0, 99) < 5);
                if (((w - m_r + 32) % 32) < 16 && $urandom_range(0, 99) < 50)
                    w = (w + 1) % 32;
                mstep("rand", rd, clr, w);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
